// File: rtl/frame_sequencer.sv
// ----------------------------------------------------------------------------
// frame_sequencer
// Per-frame controller for the render pipeline. Each frame it clears the back
// framebuffer and z-buffer through the clear port, starts the geometry engine,
// waits for geometry, vertex FIFO, assembler and rasterizer to drain, then
// swaps front/back buffers on the next display vsync rising edge.
// The rasterizer owns the FB/ZB write ports only while o_raster_en is high;
// otherwise the external write mux selects the clear port.
// ----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int unsigned FB_DEPTH     = 76800,
    parameter int unsigned ADDR_W       = 17,
    parameter logic [11:0] CLEAR_COLOR  = 12'h000,
    parameter logic [7:0]  Z_FAR        = 8'hFF,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_vsync,
    input  logic              i_geo_done,
    input  logic              i_fifo_empty,
    input  logic              i_asm_idle,
    input  logic              i_raster_busy,
    output logic              o_geo_start,
    output logic              o_raster_en,
    output logic              o_clear_we,
    output logic [ADDR_W-1:0] o_clear_addr,
    output logic [11:0]       o_clear_pixel,
    output logic [7:0]        o_clear_zb_data,
    output logic              o_front_buf,
    output logic [15:0]       o_frame_count,
    output logic              o_frame_overrun,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_RENDER     = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_WAIT_VSYNC = 3'd4,
        ST_SWAP       = 3'd5
    } state_t;

    // Drain counter is one bit wider than strictly needed so DRAIN_CYCLES=1
    // still yields a legal, non-zero-width vector.
    localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_DEPTH - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    state_t              state;
    logic [DCNT_W-1:0]   drain_cnt;
    logic                vsync_q;
    logic                vsync_rise;
    logic                pipe_idle;

    // The whole pipeline counts as idle only when nothing is queued, no
    // partial triangle is held, and the rasterizer has finished.
    assign pipe_idle  = i_fifo_empty & i_asm_idle & ~i_raster_busy;
    assign vsync_rise = i_vsync & ~vsync_q;
    assign o_state    = state;

    // Previous vsync sample for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
        end
    end

    // Frame state machine; every output is registered here so it changes in
    // the same cycle the state it belongs to becomes visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            drain_cnt       <= '0;
            o_geo_start     <= 1'b0;
            o_raster_en     <= 1'b0;
            o_clear_we      <= 1'b0;
            o_clear_addr    <= '0;
            o_clear_pixel   <= 12'h000;
            o_clear_zb_data <= 8'h00;
            o_front_buf     <= 1'b0;
            o_frame_count   <= 16'h0000;
            o_frame_overrun <= 1'b0;
        end else begin
            // Geometry start is a single-cycle strobe; it is re-armed only on
            // the CLEAR -> RENDER transition.
            o_geo_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_enable) begin
                        state           <= ST_CLEAR;
                        o_clear_we      <= 1'b1;
                        o_clear_addr    <= '0;
                        o_clear_pixel   <= CLEAR_COLOR;
                        o_clear_zb_data <= Z_FAR;
                    end
                end

                ST_CLEAR: begin
                    // A vsync edge here means the previous swap point was
                    // missed; flag it and let the frame wait for the next edge.
                    if (vsync_rise) begin
                        o_frame_overrun <= 1'b1;
                    end
                    if (o_clear_addr == LAST_ADDR) begin
                        state           <= ST_RENDER;
                        o_clear_we      <= 1'b0;
                        o_clear_addr    <= '0;
                        o_clear_pixel   <= 12'h000;
                        o_clear_zb_data <= 8'h00;
                        o_geo_start     <= 1'b1;
                        o_raster_en     <= 1'b1;
                    end else begin
                        o_clear_addr <= o_clear_addr + 1'b1;
                    end
                end

                ST_RENDER: begin
                    if (vsync_rise) begin
                        o_frame_overrun <= 1'b1;
                    end
                    if (i_geo_done) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end

                ST_DRAIN: begin
                    if (vsync_rise) begin
                        o_frame_overrun <= 1'b1;
                    end
                    // Any activity restarts the quiet-period count, so only an
                    // uninterrupted idle run of DRAIN_CYCLES ends the frame.
                    if (!pipe_idle) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt   <= '0;
                        o_raster_en <= 1'b0;
                        state       <= ST_WAIT_VSYNC;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                ST_WAIT_VSYNC: begin
                    if (vsync_rise) begin
                        state         <= ST_SWAP;
                        o_front_buf   <= ~o_front_buf;
                        o_frame_count <= o_frame_count + 16'd1;
                    end
                end

                ST_SWAP: begin
                    // i_enable is only consulted at frame boundaries so a
                    // frame already in flight always completes.
                    if (i_enable) begin
                        state           <= ST_CLEAR;
                        o_clear_we      <= 1'b1;
                        o_clear_addr    <= '0;
                        o_clear_pixel   <= CLEAR_COLOR;
                        o_clear_zb_data <= Z_FAR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    // Corrupted encoding: release the write ports and restart.
                    state           <= ST_IDLE;
                    drain_cnt       <= '0;
                    o_raster_en     <= 1'b0;
                    o_clear_we      <= 1'b0;
                    o_clear_addr    <= '0;
                    o_clear_pixel   <= 12'h000;
                    o_clear_zb_data <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_frame_sequencer
// Directed scenarios followed by randomized multi-frame traffic for
// frame_sequencer (FB_DEPTH=16, DRAIN_CYCLES=4). Expected outputs are built
// from frame-level bookkeeping kept in the bench.
// ----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int FB = 16;
    localparam int AW = 4;
    localparam int DC = 4;

    localparam int S_IDLE  = 0;
    localparam int S_CLEAR = 1;
    localparam int S_REND  = 2;
    localparam int S_DRAIN = 3;
    localparam int S_WAIT  = 4;
    localparam int S_SWAP  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          vsync;
    logic          geo_done;
    logic          fifo_empty;
    logic          asm_idle;
    logic          raster_busy;
    logic          geo_start;
    logic          raster_en;
    logic          clear_we;
    logic [AW-1:0] clear_addr;
    logic [11:0]   clear_pixel;
    logic [7:0]    clear_zb;
    logic          front_buf;
    logic [15:0]   frame_count;
    logic          frame_overrun;
    logic [2:0]    state;

    int compared   = 0;
    int mismatched = 0;

    // Frame-level bookkeeping
    bit m_front;
    int m_count;
    bit m_ovr;
    bit m_vprev;

    logic [47:0] obs;
    assign obs = {state, geo_start, raster_en, clear_we, clear_addr, clear_pixel,
                  clear_zb, front_buf, frame_count, frame_overrun};

    frame_sequencer #(
        .FB_DEPTH     (FB),
        .ADDR_W       (AW),
        .CLEAR_COLOR  (12'h000),
        .Z_FAR        (8'hFF),
        .DRAIN_CYCLES (DC)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_vsync         (vsync),
        .i_geo_done      (geo_done),
        .i_fifo_empty    (fifo_empty),
        .i_asm_idle      (asm_idle),
        .i_raster_busy   (raster_busy),
        .o_geo_start     (geo_start),
        .o_raster_en     (raster_en),
        .o_clear_we      (clear_we),
        .o_clear_addr    (clear_addr),
        .o_clear_pixel   (clear_pixel),
        .o_clear_zb_data (clear_zb),
        .o_front_buf     (front_buf),
        .o_frame_count   (frame_count),
        .o_frame_overrun (frame_overrun),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // Expected output vector: the clear data ports carry constants only while
    // the clear write enable is high.
    function automatic logic [47:0] mk(input int st, input bit gs, input bit re, input bit we,
                                       input int addr, input bit fr, input int cnt, input bit ovr);
        logic [7:0] zb;
        logic [2:0] s3;
        logic [AW-1:0] a;
        logic [15:0] c;
        zb = we ? 8'hFF : 8'h00;
        s3 = st[2:0];
        a  = addr[AW-1:0];
        c  = cnt[15:0];
        return {s3, gs, re, we, a, 12'h000, zb, fr, c, ovr};
    endfunction

    task automatic tick;
        @(posedge clk);
        m_vprev = rst_n ? vsync : 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [47:0] e;
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; geo_done = 1'b0;
        fifo_empty = 1'b1; asm_idle = 1'b1; raster_busy = 1'b0;
        repeat (3) tick;
        m_front = 1'b0; m_count = 0; m_ovr = 1'b0;
        e = mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL reset_hold: got %h expected %h", obs, e);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL idle_stay[%0d]: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_clear;
        logic [47:0] e;
        enable = 1'b1;
        tick;
        for (int i = 0; i < FB; i++) begin
            e = mk(S_CLEAR, 0, 0, 1, i, m_front, m_count, m_ovr);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL clear_addr[%0d]: got %h expected %h", i, obs, e);
            end
            geo_done = (i == 3);   // must be ignored outside RENDER
            tick;
        end
        e = mk(S_REND, 1, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL geo_start: got %h expected %h", obs, e);
        end
        tick;
        e = mk(S_REND, 0, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL render_hold: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_drain;
        logic [47:0] e;
        bit pat [5];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        geo_done = 1'b1;
        tick;
        geo_done = 1'b0;
        e = mk(S_DRAIN, 0, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL drain_enter: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 5; i++) begin
            raster_busy = pat[i];
            tick;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL drain_busy[%0d]: got %h expected %h", i, obs, e);
            end
        end
        raster_busy = 1'b0;
        for (int k = 1; k <= DC; k++) begin
            tick;
            if (k < DC) e = mk(S_DRAIN, 0, 1, 0, 0, m_front, m_count, m_ovr);
            else        e = mk(S_WAIT, 0, 0, 0, 0, m_front, m_count, m_ovr);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL drain_count[%0d]: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_swap;
        logic [47:0] e;
        vsync = 1'b0;
        e = mk(S_WAIT, 0, 0, 0, 0, m_front, m_count, m_ovr);
        for (int i = 0; i < 2; i++) begin
            tick;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL wait_hold[%0d]: got %h expected %h", i, obs, e);
            end
        end
        vsync = 1'b1;
        tick;
        m_front = ~m_front; m_count++;
        e = mk(S_SWAP, 0, 0, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL swap: got %h expected %h", obs, e);
        end
        vsync = 1'b0;
        tick;
        for (int i = 0; i < FB; i++) begin
            e = mk(S_CLEAR, 0, 0, 1, i, m_front, m_count, m_ovr);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL clear_restart[%0d]: got %h expected %h", i, obs, e);
            end
            tick;
        end
        e = mk(S_REND, 1, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL second_geo_start: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_overrun;
        logic [47:0] e;
        vsync = 1'b1;
        tick;
        m_ovr = 1'b1;
        e = mk(S_REND, 0, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL overrun_set: got %h expected %h", obs, e);
        end
        vsync = 1'b0;
        tick;
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL overrun_sticky: got %h expected %h", obs, e);
        end
        geo_done = 1'b1;
        tick;
        geo_done = 1'b0;
        repeat (DC - 1) tick;
        e = mk(S_DRAIN, 0, 1, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL overrun_drain: got %h expected %h", obs, e);
        end
        tick;
        e = mk(S_WAIT, 0, 0, 0, 0, m_front, m_count, m_ovr);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL no_swap_old_edge[%0d]: got %h expected %h", i, obs, e);
            end
            tick;
        end
        vsync = 1'b1;
        tick;
        m_front = ~m_front; m_count++;
        e = mk(S_SWAP, 0, 0, 0, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL overrun_swap: got %h expected %h", obs, e);
        end
        vsync = 1'b0;
        tick;
        e = mk(S_CLEAR, 0, 0, 1, 0, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL overrun_clear: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [47:0] e;
        repeat (7) tick;
        e = mk(S_CLEAR, 0, 0, 1, 7, m_front, m_count, m_ovr);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL clear_at7: got %h expected %h", obs, e);
        end
        rst_n = 1'b0;
        tick;
        m_front = 1'b0; m_count = 0; m_ovr = 1'b0;
        e = mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL reset_mid_clear: got %h expected %h", obs, e);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        tick;
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] e;
        int frames;
        int nr;
        int run;
        bit done;
        bit edge_now;
        frames = 8;
        enable = 1'b1;
        vsync  = 1'b0;
        tick;
        for (int f = 0; f < frames; f++) begin
            // Clear phase: vsync edges here are overruns; enable and
            // geo_done are don't-cares.
            for (int i = 0; i < FB; i++) begin
                e = mk(S_CLEAR, 0, 0, 1, i, m_front, m_count, m_ovr);
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_clear f%0d[%0d]: got %h expected %h", f, i, obs, e);
                end
                vsync = ($urandom % 24) == 0;
                enable = $urandom % 2;
                geo_done = ($urandom % 4) == 0;
                raster_busy = $urandom % 2;
                if (vsync && !m_vprev) m_ovr = 1'b1;
                tick;
            end
            geo_done = 1'b0;
            e = mk(S_REND, 1, 1, 0, 0, m_front, m_count, m_ovr);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL rnd_geo_start f%0d: got %h expected %h", f, obs, e);
            end
            // Render phase of random length
            nr = $urandom_range(0, 4);
            for (int j = 0; j < nr; j++) begin
                vsync = ($urandom % 24) == 0;
                enable = $urandom % 2;
                if (vsync && !m_vprev) m_ovr = 1'b1;
                tick;
                e = mk(S_REND, 0, 1, 0, 0, m_front, m_count, m_ovr);
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_render f%0d[%0d]: got %h expected %h", f, j, obs, e);
                end
            end
            geo_done = 1'b1;
            vsync = ($urandom % 24) == 0;
            if (vsync && !m_vprev) m_ovr = 1'b1;
            tick;
            geo_done = 1'b0;
            e = mk(S_DRAIN, 0, 1, 0, 0, m_front, m_count, m_ovr);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL rnd_drain_enter f%0d: got %h expected %h", f, obs, e);
            end
            // Drain: need DC consecutive idle cycles
            run = 0;
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (c >= 40) begin
                    fifo_empty = 1'b1; asm_idle = 1'b1; raster_busy = 1'b0;
                end else begin
                    fifo_empty  = ($urandom % 5) != 0;
                    asm_idle    = ($urandom % 5) != 0;
                    raster_busy = ($urandom % 5) == 0;
                end
                vsync = ($urandom % 24) == 0;
                enable = $urandom % 2;
                if (vsync && !m_vprev) m_ovr = 1'b1;
                run = (fifo_empty && asm_idle && !raster_busy) ? run + 1 : 0;
                tick;
                if (run == DC) begin
                    done = 1'b1;
                    e = mk(S_WAIT, 0, 0, 0, 0, m_front, m_count, m_ovr);
                end else begin
                    e = mk(S_DRAIN, 0, 1, 0, 0, m_front, m_count, m_ovr);
                end
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_drain f%0d[%0d]: got %h expected %h", f, c, obs, e);
                end
            end
            fifo_empty = 1'b1; asm_idle = 1'b1; raster_busy = 1'b0;
            // Wait for a vsync rising edge
            done = 1'b0;
            for (int w = 0; w < 30 && !done; w++) begin
                if (w >= 25) vsync = !m_vprev;
                else         vsync = ($urandom % 4) == 0;
                enable = $urandom % 2;
                edge_now = vsync && !m_vprev;
                tick;
                if (edge_now) begin
                    done = 1'b1;
                    m_front = ~m_front;
                    m_count++;
                    e = mk(S_SWAP, 0, 0, 0, 0, m_front, m_count, m_ovr);
                end else begin
                    e = mk(S_WAIT, 0, 0, 0, 0, m_front, m_count, m_ovr);
                end
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_wait f%0d[%0d]: got %h expected %h", f, w, obs, e);
                end
            end
            // Swap cycle: enable decides whether another frame follows
            enable = (f == frames - 1) ? 1'b0 : (($urandom % 3) != 0);
            vsync = $urandom % 2;
            tick;
            if (enable) begin
                e = mk(S_CLEAR, 0, 0, 1, 0, m_front, m_count, m_ovr);
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_restart f%0d: got %h expected %h", f, obs, e);
                end
            end else begin
                e = mk(S_IDLE, 0, 0, 0, 0, m_front, m_count, m_ovr);
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL rnd_to_idle f%0d: got %h expected %h", f, obs, e);
                end
                nr = $urandom_range(0, 3);
                for (int k = 0; k < nr; k++) begin
                    vsync = $urandom % 2;
                    tick;
                    compared++;
                    if (obs !== e) begin
                        mismatched++;
                        $display("FAIL rnd_idle f%0d[%0d]: got %h expected %h", f, k, obs, e);
                    end
                end
                if (f < frames - 1) begin
                    enable = 1'b1;
                    vsync = $urandom % 2;
                    tick;
                    e = mk(S_CLEAR, 0, 0, 1, 0, m_front, m_count, m_ovr);
                    compared++;
                    if (obs !== e) begin
                        mismatched++;
                        $display("FAIL rnd_idle_start f%0d: got %h expected %h", f, obs, e);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; geo_done = 1'b0;
        fifo_empty = 1'b1; asm_idle = 1'b1; raster_busy = 1'b0;
        m_front = 1'b0; m_count = 0; m_ovr = 1'b0; m_vprev = 1'b0;
        #1;
        test_reset;
        test_clear;
        test_drain;
        test_swap;
        test_overrun;
        test_reset_mid_clear;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
